// File: rtl/uart_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_core
// Purpose  : Full-duplex UART core with programmable baud tick, oversampled RX
//            and an RX FIFO holding data plus parity/framing flags per entry.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_core #(
    parameter int OVS        = 16,
    parameter int DIV_W      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DIV_W-1:0]             baud_div,
    input  logic [1:0]                   cfg_len,
    input  logic                         cfg_par_en,
    input  logic                         cfg_par_odd,
    input  logic                         cfg_stop2,
    input  logic [7:0]                   tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic                         tx_busy,
    output logic                         tx_sn,
    input  logic                         rx_sn,
    output logic [7:0]                   rx_data,
    output logic                         rx_perr,
    output logic                         rx_ferr,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]  rx_count,
    output logic                         rx_overrun,
    input  logic                         ovr_clr
);
    localparam int c_CNT_W = $clog2(2 * OVS);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST   = c_CNT_W'(OVS - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST  = c_CNT_W'(OVS / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_STOP2_LAST = c_CNT_W'(2 * OVS - 1);

    // ---------------- baud tick ----------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;
    assign w_tick = (r_div_cnt == baud_div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_div_cnt <= '0;
        else if (r_div_cnt >= baud_div) r_div_cnt <= '0;
        else                            r_div_cnt <= r_div_cnt + DIV_W'(1);
    end

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_WAIT  = 3'd1,
        TX_START = 3'd2,
        TX_DATA  = 3'd3,
        TX_PAR   = 3'd4,
        TX_STOP  = 3'd5
    } tx_state_t;

    tx_state_t          r_tx_state, w_tx_state_nxt;
    logic [c_CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]         r_tx_idx, w_tx_idx_nxt, w_tx_idx_inc;
    logic               r_tx_sn, w_tx_sn_nxt;
    logic               r_tx_ready, r_tx_busy;
    logic [7:0]         r_tx_data, w_tx_masked;
    logic [2:0]         r_tx_last;
    logic               r_tx_par_en, r_tx_par, r_tx_stop2;

    assign w_tx_masked = tx_data & (8'hFF >> (2'd3 - cfg_len));

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_idx_nxt   = r_tx_idx;
        w_tx_sn_nxt    = r_tx_sn;
        w_tx_idx_inc   = r_tx_idx + 3'd1;
        case (r_tx_state)
            TX_IDLE: if (tx_valid) w_tx_state_nxt = TX_WAIT;
            TX_WAIT: if (w_tick) begin
                w_tx_state_nxt = TX_START;
                w_tx_cnt_nxt   = '0;
                w_tx_sn_nxt    = 1'b0;
            end
            TX_START: if (w_tick) begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_state_nxt = TX_DATA;
                    w_tx_cnt_nxt   = '0;
                    w_tx_idx_nxt   = 3'd0;
                    w_tx_sn_nxt    = r_tx_data[0];
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + c_CNT_W'(1);
                end
            end
            TX_DATA: if (w_tick) begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_idx == r_tx_last) begin
                        w_tx_state_nxt = r_tx_par_en ? TX_PAR : TX_STOP;
                        w_tx_sn_nxt    = r_tx_par_en ? r_tx_par : 1'b1;
                    end else begin
                        w_tx_idx_nxt = w_tx_idx_inc;
                        w_tx_sn_nxt  = r_tx_data[w_tx_idx_inc];
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + c_CNT_W'(1);
                end
            end
            TX_PAR: if (w_tick) begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_state_nxt = TX_STOP;
                    w_tx_cnt_nxt   = '0;
                    w_tx_sn_nxt    = 1'b1;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + c_CNT_W'(1);
                end
            end
            TX_STOP: if (w_tick) begin
                if (r_tx_cnt == (r_tx_stop2 ? c_STOP2_LAST : c_BIT_LAST)) w_tx_state_nxt = TX_IDLE;
                else w_tx_cnt_nxt = r_tx_cnt + c_CNT_W'(1);
            end
            default: begin
                w_tx_state_nxt = TX_IDLE;
                w_tx_sn_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state  <= TX_IDLE;
            r_tx_cnt    <= '0;
            r_tx_idx    <= 3'd0;
            r_tx_sn     <= 1'b1;
            r_tx_ready  <= 1'b1;
            r_tx_busy   <= 1'b0;
            r_tx_data   <= 8'h00;
            r_tx_last   <= 3'd7;
            r_tx_par_en <= 1'b0;
            r_tx_par    <= 1'b0;
            r_tx_stop2  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            r_tx_sn    <= w_tx_sn_nxt;
            r_tx_ready <= (w_tx_state_nxt == TX_IDLE);
            r_tx_busy  <= (w_tx_state_nxt != TX_IDLE);
            if (tx_valid && r_tx_ready) begin
                r_tx_data   <= w_tx_masked;
                r_tx_last   <= 3'd4 + {1'b0, cfg_len};
                r_tx_par_en <= cfg_par_en;
                r_tx_par    <= (^w_tx_masked) ^ cfg_par_odd;
                r_tx_stop2  <= cfg_stop2;
            end
        end
    end

    assign tx_ready = r_tx_ready;
    assign tx_busy  = r_tx_busy;
    assign tx_sn    = r_tx_sn;

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_PAR   = 3'd3,
        RX_STOP  = 3'd4
    } rx_state_t;

    logic               r_rx_meta, r_rx_sync;
    rx_state_t          r_rx_state, w_rx_state_nxt;
    logic [c_CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]         r_rx_idx, w_rx_idx_nxt;
    logic [7:0]         r_rx_data;
    logic [2:0]         r_rx_last;
    logic               r_rx_par_en, r_rx_odd, r_rx_perr;
    logic               w_rx_det, w_rx_samp_bit, w_rx_samp_par, w_rx_done;
    logic               r_push;
    logic [9:0]         r_push_word;

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_idx_nxt   = r_rx_idx;
        w_rx_det       = 1'b0;
        w_rx_samp_bit  = 1'b0;
        w_rx_samp_par  = 1'b0;
        w_rx_done      = 1'b0;
        case (r_rx_state)
            RX_IDLE: if (w_tick && !r_rx_sync) begin
                w_rx_state_nxt = RX_START;
                w_rx_cnt_nxt   = '0;
                w_rx_det       = 1'b1;
            end
            RX_START: if (w_tick) begin
                if (r_rx_cnt == c_HALF_LAST) begin
                    w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
                    w_rx_cnt_nxt   = '0;
                    w_rx_idx_nxt   = 3'd0;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + c_CNT_W'(1);
                end
            end
            RX_DATA: if (w_tick) begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_samp_bit = 1'b1;
                    w_rx_cnt_nxt  = '0;
                    if (r_rx_idx == r_rx_last) w_rx_state_nxt = r_rx_par_en ? RX_PAR : RX_STOP;
                    else w_rx_idx_nxt = r_rx_idx + 3'd1;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + c_CNT_W'(1);
                end
            end
            RX_PAR: if (w_tick) begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_samp_par  = 1'b1;
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = RX_STOP;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + c_CNT_W'(1);
                end
            end
            RX_STOP: if (w_tick) begin
                // Return to idle at stop centre so a following start edge is not missed.
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_done      = 1'b1;
                    w_rx_state_nxt = RX_IDLE;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + c_CNT_W'(1);
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_rx_idx    <= 3'd0;
            r_rx_data   <= 8'h00;
            r_rx_last   <= 3'd7;
            r_rx_par_en <= 1'b0;
            r_rx_odd    <= 1'b0;
            r_rx_perr   <= 1'b0;
            r_push      <= 1'b0;
            r_push_word <= 10'h000;
        end else begin
            r_rx_meta  <= rx_sn;
            r_rx_sync  <= r_rx_meta;
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_idx   <= w_rx_idx_nxt;
            if (w_rx_det) begin
                r_rx_data   <= 8'h00;
                r_rx_last   <= 3'd4 + {1'b0, cfg_len};
                r_rx_par_en <= cfg_par_en;
                r_rx_odd    <= cfg_par_odd;
                r_rx_perr   <= 1'b0;
            end
            if (w_rx_samp_bit) r_rx_data[r_rx_idx] <= r_rx_sync;
            if (w_rx_samp_par) r_rx_perr <= r_rx_sync ^ (^r_rx_data) ^ r_rx_odd;
            r_push <= w_rx_done;
            if (w_rx_done) r_push_word <= {~r_rx_sync, r_rx_perr, r_rx_data};
        end
    end

    // ---------------- RX FIFO ----------------
    logic [9:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_PTR_W:0]   r_count, w_count_nxt;
    logic               r_valid, r_ovr;
    logic               w_pop, w_full, w_push_ok, w_ovr_set;
    logic [9:0]         w_head;

    assign w_pop     = r_valid && rx_ready;
    assign w_full    = (r_count == (c_PTR_W + 1)'(FIFO_DEPTH));
    assign w_push_ok = r_push && (!w_full || w_pop);
    assign w_ovr_set = r_push && w_full && !w_pop;
    assign w_head    = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop)      w_count_nxt = r_count + (c_PTR_W + 1)'(1);
        else if (!w_push_ok && w_pop) w_count_nxt = r_count - (c_PTR_W + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= r_push_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            if (w_ovr_set)    r_ovr <= 1'b1;
            else if (ovr_clr) r_ovr <= 1'b0;
        end
    end

    // Head is gated so an empty FIFO never exposes stale or uninitialised storage.
    assign rx_data    = r_valid ? w_head[7:0] : 8'h00;
    assign rx_perr    = r_valid & w_head[8];
    assign rx_ferr    = r_valid & w_head[9];
    assign rx_valid   = r_valid;
    assign rx_count   = r_count;
    assign rx_overrun = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_core
// Purpose  : Directed self-checking bench for uart_fifo_core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_core;
    localparam int OVS        = 16;
    localparam int DIV_W      = 12;
    localparam int FIFO_DEPTH = 4;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [DIV_W-1:0]            baud_div = '0;
    logic [1:0]                  cfg_len = 2'd3;
    logic                        cfg_par_en = 1'b0;
    logic                        cfg_par_odd = 1'b0;
    logic                        cfg_stop2 = 1'b0;
    logic [7:0]                  tx_data = 8'h00;
    logic                        tx_valid = 1'b0;
    logic                        tx_ready, tx_busy, tx_sn;
    logic                        rx_sn;
    logic [7:0]                  rx_data;
    logic                        rx_perr, rx_ferr, rx_valid;
    logic                        rx_ready = 1'b0;
    logic [$clog2(FIFO_DEPTH):0] rx_count;
    logic                        rx_overrun;
    logic                        ovr_clr = 1'b0;

    logic loop_en = 1'b0;
    logic rx_drv  = 1'b1;
    assign rx_sn = loop_en ? tx_sn : rx_drv;

    int vectors     = 0;
    int miscompares = 0;

    uart_fifo_core #(.OVS(OVS), .DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .baud_div(baud_div),
        .cfg_len(cfg_len), .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_sn(tx_sn),
        .rx_sn(rx_sn), .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_count(rx_count), .rx_overrun(rx_overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    // Cycles from tx_sn falling to tx_ready rising, first high after the start bit,
    // and the line value samp_at cycles after the fall.
    task automatic measure_frame(input int samp_at, output int len, output int first_high,
                                 output logic samp_val);
        int n;
        n = 0;
        len = -1;
        first_high = -1;
        samp_val = 1'bx;
        while (tx_sn !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (tx_sn !== 1'b0) begin
            chk("tx_start_timeout", tx_sn, 0);
            return;
        end
        n = 0;
        while (tx_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
            if (first_high < 0 && tx_sn === 1'b1) first_high = n;
            if (n == samp_at) samp_val = tx_sn;
        end
        len = n;
    endtask

    // Drives one frame on rx_drv; pop_at >= 0 raises rx_ready for exactly that cycle.
    task automatic drive_frame(input logic [7:0] d, input int nbits, input bit par_present,
                               input logic par_bit, input logic stop_bit, input int nstop,
                               input int pop_at);
        logic [11:0] seq;
        int nb;
        int bitcyc;
        bitcyc = OVS * (int'(baud_div) + 1);
        seq = '1;
        nb = 0;
        seq[nb] = 1'b0;
        nb++;
        for (int i = 0; i < nbits; i++) begin
            seq[nb] = d[i];
            nb++;
        end
        if (par_present) begin
            seq[nb] = par_bit;
            nb++;
        end
        for (int i = 0; i < nstop; i++) begin
            seq[nb] = stop_bit;
            nb++;
        end
        for (int c = 0; c < nb * bitcyc; c++) begin
            rx_drv = seq[c / bitcyc];
            if (pop_at >= 0) rx_ready = (c == pop_at);
            @(negedge clk);
        end
        rx_drv = 1'b1;
        if (pop_at >= 0) rx_ready = 1'b0;
    endtask

    int   flen, fhigh;
    logic fsamp;

    initial begin
        // Reset state
        cycles(3);
        chk("rst_tx_sn", tx_sn, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_flags", {rx_perr, rx_ferr}, 0);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_rx_overrun", rx_overrun, 0);
        rst = 1'b0;
        cycles(2);

        // 8N1 loopback, 0xA5
        loop_en = 1'b1;
        send_tx(8'hA5);
        chk("acc_tx_ready", tx_ready, 0);
        chk("acc_tx_busy", tx_busy, 1);
        chk("acc_tx_sn_still_high", tx_sn, 1);
        measure_frame(-1, flen, fhigh, fsamp);
        chk("8n1_frame_len", flen, 160);
        chk("8n1_start_len", fhigh, 16);
        chk("8n1_rx_count", rx_count, 1);
        chk("8n1_rx_valid", rx_valid, 1);
        chk("8n1_rx_data", rx_data, 8'hA5);
        chk("8n1_rx_flags", {rx_perr, rx_ferr}, 0);
        pop_one();
        chk("8n1_pop_count", rx_count, 0);
        chk("8n1_pop_valid", rx_valid, 0);
        chk("8n1_pop_data", rx_data, 0);

        // 7E2 loopback; bit 7 of 0xD5 lies above the word length and is ignored
        cfg_len = 2'd2;
        cfg_par_en = 1'b1;
        cfg_par_odd = 1'b0;
        cfg_stop2 = 1'b1;
        send_tx(8'hD5);
        measure_frame(136, flen, fhigh, fsamp);
        chk("7e2_frame_len", flen, 176);
        chk("7e2_parity_bit", fsamp, 0);
        cycles(2);
        chk("7e2_rx_data", rx_data, 8'h55);
        chk("7e2_rx_flags", {rx_perr, rx_ferr}, 0);
        chk("7e2_rx_count", rx_count, 1);
        pop_one();

        // 7E2 with inverted parity bit
        loop_en = 1'b0;
        drive_frame(8'h55, 7, 1'b1, 1'b1, 1'b1, 2, -1);
        cycles(4);
        chk("badpar_perr", rx_perr, 1);
        chk("badpar_ferr", rx_ferr, 0);
        chk("badpar_data", rx_data, 8'h55);
        pop_one();

        // Short low glitch must not produce a frame
        cfg_len = 2'd3;
        cfg_par_en = 1'b0;
        cfg_stop2 = 1'b0;
        rx_drv = 1'b0;
        cycles(4);
        rx_drv = 1'b1;
        cycles(40);
        chk("glitch_count", rx_count, 0);
        chk("glitch_valid", rx_valid, 0);

        // Low stop bit: framing error, data still delivered
        drive_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1, -1);
        cycles(20);
        chk("ferr_count", rx_count, 1);
        chk("ferr_flag", rx_ferr, 1);
        chk("ferr_perr", rx_perr, 0);
        chk("ferr_data", rx_data, 8'h3C);
        pop_one();

        // Fill FIFO then overrun
        drive_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1, -1);
        drive_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1, -1);
        drive_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 1, -1);
        drive_frame(8'h44, 8, 1'b0, 1'b0, 1'b1, 1, -1);
        cycles(4);
        chk("full_overrun_clear", rx_overrun, 0);
        drive_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1, -1);
        cycles(4);
        chk("full_count", rx_count, 4);
        chk("full_overrun", rx_overrun, 1);
        chk("full_head", rx_data, 8'h11);
        pop_one();
        chk("pop_count", rx_count, 3);
        chk("pop_head", rx_data, 8'h22);
        chk("pop_overrun_sticky", rx_overrun, 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("clr_overrun", rx_overrun, 0);
        chk("clr_count", rx_count, 3);

        // Push coinciding with pop while full
        drive_frame(8'h66, 8, 1'b0, 1'b0, 1'b1, 1, -1);
        cycles(4);
        chk("refill_count", rx_count, 4);
        drive_frame(8'h77, 8, 1'b0, 1'b0, 1'b1, 1, 155);
        cycles(4);
        chk("pushpop_count", rx_count, 4);
        chk("pushpop_overrun", rx_overrun, 0);
        chk("pushpop_head", rx_data, 8'h33);
        pop_one();
        chk("drain_head_44", rx_data, 8'h44);
        pop_one();
        chk("drain_head_66", rx_data, 8'h66);
        chk("drain_count", rx_count, 2);

        // Reset during TX data phase; FIFO still holds two entries
        loop_en = 1'b1;
        send_tx(8'hC3);
        cycles(50);
        chk("pre_rst_busy", tx_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx_sn", tx_sn, 1);
        chk("midrst_tx_ready", tx_ready, 1);
        rst = 1'b0;
        cycles(2);
        chk("postrst_tx_busy", tx_busy, 0);
        chk("postrst_rx_count", rx_count, 0);
        chk("postrst_rx_valid", rx_valid, 0);

        // baud_div = 3: 64 clk per bit
        baud_div = DIV_W'(3);
        send_tx(8'hA5);
        measure_frame(-1, flen, fhigh, fsamp);
        chk("div3_frame_len", flen, 640);
        chk("div3_start_len", fhigh, 64);
        cycles(2);
        chk("div3_rx_count", rx_count, 1);
        chk("div3_rx_data", rx_data, 8'hA5);
        chk("div3_rx_flags", {rx_perr, rx_ferr}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_fifo_core.md
# uart_fifo_core

Parametrised second-generation UART core: full-duplex, 5–8 data bits, optional even/odd parity, 1 or 2 stop bits. It generates its own baud tick from a programmable divisor and oversamples RX at a parameter-set rate with start-bit validation. Received frames are buffered in an N-deep FIFO with per-entry error flags. Interfaces are valid/ready in both directions, for use behind the top-level pin wrapper.

## Interface
- OVS, 16: oversampling ticks per bit; even, ≥4.
- DIV_W, 12: baud divisor width.
- FIFO_DEPTH, 4: RX FIFO entries; power of two, ≥2.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- baud_div  in  DIV_W  one tick every baud_div+1 clk cycles (0 = tick every cycle)
- cfg_len  in  2  data bits = 5 + cfg_len
- cfg_par_en  in  1  parity bit present
- cfg_par_odd  in  1  1 = odd parity, 0 = even
- cfg_stop2  in  1  1 = two stop bits
- tx_data  in  8  TX word, LSB first; bits above length ignored
- tx_valid  in  1  TX request
- tx_ready  out  1  TX accepts a word (TX idle)
- tx_busy  out  1  frame in progress
- tx_sn  out  1  serial out, idle high
- rx_sn  in  1  serial in, asynchronous
- rx_data  out  8  FIFO head, right-justified, unused upper bits 0
- rx_perr  out  1  parity error flag of head entry
- rx_ferr  out  1  framing error flag of head entry
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  pop head when rx_valid
- rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- rx_overrun  out  1  sticky, frame dropped on full FIFO
- ovr_clr  in  1  clears rx_overrun

## Operation
- Tick generator: counter 0..baud_div, tick pulse when counter == baud_div, then wraps to 0. baud_div is sampled live. TX and RX advance only on ticks.
- Config latched per frame: TX latches at acceptance, RX at start-bit detection. Mid-frame config changes do not affect the current frame.
- TX FSM IDLE→START→DATA→PARITY (if enabled)→STOP→IDLE:
  - Handshake: tx_valid && tx_ready at a clk edge latches data and config. tx_ready is low from the next cycle.
  - Each bit is held for OVS ticks. The first tick after acceptance begins START.
  - Even parity: bit makes total ones (data+parity) even. Odd parity: inverted.
  - STOP lasts OVS or 2·OVS ticks. tx_ready returns high the cycle after the last stop tick.
- RX path: rx_sn passes through a 2-flop synchroniser, reset to 1.
- RX FSM IDLE→START→DATA→PARITY→STOP→IDLE:
  - IDLE: synchronised low seen at a tick → START, counter 0.
  - START: at OVS/2 ticks, re-sample. High → false start, back to IDLE, nothing pushed. Low → DATA.
  - Each subsequent bit is sampled at OVS ticks after the previous sample (bit centre).
  - perr = received parity ≠ computed parity (0 when parity disabled).
  - ferr = stop sample low. Only the first stop bit is checked on RX.
  - At the stop sample: push {ferr, perr, data}, then go to IDLE immediately so back-to-back frames are caught.
- FIFO:
  - Push when not full, or when full with a pop in the same cycle (pop+push keeps count).
  - Push while full without pop: frame dropped, rx_overrun ← 1.
  - Pop on empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - ovr_clr and an overrun in the same cycle: set wins.
- Reset, including mid-frame: all state cleared, partial frames discarded, FIFO emptied.

## Timing
- Reset values: tx_sn=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, rx_perr=0, rx_ferr=0, rx_count=0, rx_overrun=0.
- All outputs are registered except rx_data/rx_perr/rx_ferr, which are FIFO head reads.
- tx_sn falls on the first tick edge after acceptance.
- Frame length: (1 + len + par + stop)·OVS ticks.
- rx_valid and rx_count update on the clk edge after the stop-centre tick edge.
- A pop takes effect at the edge where rx_valid && rx_ready. The next head is visible in the following cycle.
- tx_busy == ~tx_ready at all times.

## Test plan
- **8N1 loopback:** baud_div=0, OVS=16, tx_sn→rx_sn, send 0xA5 → 160-cycle frame, rx_data=0xA5, perr=0, ferr=0, rx_count=1.
- **7E2:** cfg_len=2, send 0x55 → parity bit 0, two stop bits (176 cycles). RX gets 0x55. Flip the parity bit externally → rx_perr=1.
- **Glitch rejection:** 4-cycle low pulse on rx_sn → no push, FSM back to IDLE. A 0 stop bit injected on a valid frame → rx_ferr=1 with data kept.
- **FIFO full and overrun:** FIFO_DEPTH=4, 5 frames, no pops → count=4, rx_overrun=1, head is the first frame. Pop, then assert ovr_clr → count=3, overrun=0.
- **Simultaneous push/pop when full:** count stays 4, no overrun, newest frame at the tail.
- **Reset mid-TX:** assert rst during DATA → tx_sn=1, tx_ready=1 next cycle. After release, a new frame sends correctly. Also verify baud_div=3 gives 64 cycles per bit.
